// File: rtl/nibble_bus_pkg.sv
// -----------------------------------------------------------------------------
// nibble_bus_pkg
// Constants shared between the 4-bit CPU core and its memory-side responder:
// bus cycle-type codes, data-cycle sub-codes, the loader state encoding and
// the fixed geometry of the program/data stores.
// -----------------------------------------------------------------------------
package nibble_bus_pkg;

    // Cycle type carried on bus_ctl[5:4]
    localparam logic [1:0] CYC_F1   = 2'b00;
    localparam logic [1:0] CYC_F2   = 2'b01;
    localparam logic [1:0] CYC_F3   = 2'b10;
    localparam logic [1:0] CYC_DATA = 2'b11;

    // Data-cycle sub-code carried on bus_ctl[7:6]
    localparam logic [1:0] SUB_WR = 2'b00;
    localparam logic [1:0] SUB_RD = 2'b01;

    // Store geometry
    localparam int NIB_PER_INSTR = 3;
    localparam int DMEM_DEPTH    = 16;

    // Loader state
    typedef enum logic [1:0] {
        LD_IDLE    = 2'b00,
        LD_LOADING = 2'b01,
        LD_DONE    = 2'b10
    } ld_state_t;

    // Total loader slots for a given program address width
    function automatic int loader_slots(input int prog_aw);
        return NIB_PER_INSTR * (2 ** prog_aw) + DMEM_DEPTH;
    endfunction

endpackage

// File: rtl/nibble_bus_decode.sv
// -----------------------------------------------------------------------------
// nibble_bus_decode
// Purely combinational decode of one CPU nibble-bus cycle.
//
// Ports:
//   bus_addr  in  8          CPU address (PC[9:2] on fetch, {4'b0,imm} on data)
//   bus_ctl   in  8          [7:6] sub-code, [5:4] cycle type, [3:0] write data
//   bus_oe    in  8          CPU output enables
//   fetch_idx out PROG_AW    instruction index (upper bits alias away)
//   nib_sel   out 2          nibble of the instruction selected by a fetch
//   is_fetch  out 1          cycle is one of the three fetch phases
//   rd        out 1          well-formed data read
//   wr        out 1          well-formed data write (all enables driven)
//   err       out 1          malformed data cycle
//   daddr     out 4          data RAM address
//   wdata     out 4          data RAM write nibble
// -----------------------------------------------------------------------------
module nibble_bus_decode
    import nibble_bus_pkg::*;
#(
    parameter int PROG_AW = 4
) (
    input  logic [7:0]         bus_addr,
    input  logic [7:0]         bus_ctl,
    input  logic [7:0]         bus_oe,
    output logic [PROG_AW-1:0] fetch_idx,
    output logic [1:0]         nib_sel,
    output logic               is_fetch,
    output logic               rd,
    output logic               wr,
    output logic               err,
    output logic [3:0]         daddr,
    output logic [3:0]         wdata
);

    logic       is_data;
    logic [1:0] sub_code;

    assign sub_code = bus_ctl[7:6];
    assign is_data  = (bus_ctl[5:4] == CYC_DATA);
    assign is_fetch = !is_data;
    assign nib_sel  = bus_ctl[5:4];

    // The PC is split across bus_addr and the sub-code field; truncating the
    // concatenation makes instruction addresses beyond the store alias.
    assign fetch_idx = PROG_AW'({bus_addr, bus_ctl[7:6]});

    assign daddr = bus_addr[3:0];
    assign wdata = bus_ctl[3:0];

    assign rd  = is_data && (sub_code == SUB_RD);
    assign wr  = is_data && (sub_code == SUB_WR) && (bus_oe == 8'hFF);
    // A data cycle is bad if it is neither a clean read nor a clean write, or
    // if the immediate spills into the upper address nibble.
    assign err = is_data && (!(rd || wr) || (bus_addr[7:4] != 4'h0));

endmodule

// File: rtl/nibble_mem_responder.sv
// -----------------------------------------------------------------------------
// nibble_mem_responder
// Memory side of the 4-bit CPU nibble bus. Answers instruction fetches from a
// flop-based program store and data reads/writes from a 16-nibble data RAM,
// all with zero latency. A valid/ready loader port preloads both stores while
// the CPU is held in reset.
//
// Ports:
//   clk        in  1   clock
//   rst_n      in  1   synchronous active-low reset
//   bus_addr   in  8   CPU address output
//   bus_ctl    in  8   CPU uio output (sub-code, cycle type, write data)
//   bus_oe     in  8   CPU uio output enables
//   bus_rdata  out 4   nibble returned to the CPU
//   ld_en      in  1   loader mode (level)
//   ld_valid   in  1   loader nibble valid
//   ld_data    in  4   loader nibble
//   ld_ready   out 1   loader accepts a nibble this cycle
//   ld_done    out 1   every slot has been loaded
//   proto_err  out 1   sticky protocol-error flag
// -----------------------------------------------------------------------------
module nibble_mem_responder
    import nibble_bus_pkg::*;
#(
    parameter int PROG_AW = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] bus_addr,
    input  logic [7:0] bus_ctl,
    input  logic [7:0] bus_oe,
    output logic [3:0] bus_rdata,
    input  logic       ld_en,
    input  logic       ld_valid,
    input  logic [3:0] ld_data,
    output logic       ld_ready,
    output logic       ld_done,
    output logic       proto_err
);

    localparam int PROG_N = NIB_PER_INSTR * (2 ** PROG_AW);
    localparam int SLOTS  = loader_slots(PROG_AW);
    localparam int PTR_W  = $clog2(SLOTS);
    localparam logic [PTR_W-1:0] LAST_SLOT = PTR_W'(SLOTS - 1);

    // ---------------------------------------------------------------- decode
    logic [PROG_AW-1:0] fetch_idx;
    logic [1:0]         nib_sel;
    logic               is_fetch;
    logic               rd;
    logic               wr;
    logic               err;
    logic [3:0]         daddr;
    logic [3:0]         wdata;

    nibble_bus_decode #(
        .PROG_AW (PROG_AW)
    ) u_decode (
        .bus_addr  (bus_addr),
        .bus_ctl   (bus_ctl),
        .bus_oe    (bus_oe),
        .fetch_idx (fetch_idx),
        .nib_sel   (nib_sel),
        .is_fetch  (is_fetch),
        .rd        (rd),
        .wr        (wr),
        .err       (err),
        .daddr     (daddr),
        .wdata     (wdata)
    );

    // ----------------------------------------------------------- loader FSM
    ld_state_t        state_reg;
    logic [PTR_W-1:0] ptr_reg;
    logic             ld_acc;

    assign ld_ready = (state_reg == LD_LOADING);
    assign ld_done  = (state_reg == LD_DONE);
    assign ld_acc   = ld_ready && ld_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= LD_IDLE;
            ptr_reg   <= '0;
        end else if (!ld_en) begin
            // Dropping ld_en abandons any load; written nibbles are kept.
            state_reg <= LD_IDLE;
        end else begin
            case (state_reg)
                LD_IDLE: begin
                    state_reg <= LD_LOADING;
                    ptr_reg   <= '0;
                end
                LD_LOADING: begin
                    if (ld_valid) begin
                        // Hold the pointer on the last slot rather than let
                        // it wrap; DONE blocks further acceptance anyway.
                        if (ptr_reg == LAST_SLOT) begin
                            state_reg <= LD_DONE;
                        end else begin
                            ptr_reg <= ptr_reg + 1'b1;
                        end
                    end
                end
                LD_DONE:  state_reg <= LD_DONE;
                default:  state_reg <= LD_IDLE;
            endcase
        end
    end

    // -------------------------------------------------------- program store
    // Linear nibble array: instruction i occupies slots 3i, 3i+1, 3i+2.
    logic [3:0] prog_mem [PROG_N];

    generate
        for (genvar gi = 0; gi < PROG_N; gi++) begin : g_prog
            logic [3:0] nib_reg;
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    nib_reg <= 4'h0;
                end else if (ld_acc && (ptr_reg == PTR_W'(gi))) begin
                    nib_reg <= ld_data;
                end
            end
            assign prog_mem[gi] = nib_reg;
        end
    endgenerate

    // ------------------------------------------------------------- data RAM
    // Loader slots PROG_N..PROG_N+15 map to dmem[0..15]. CPU writes are only
    // honoured outside loader mode.
    logic [3:0] dmem [DMEM_DEPTH];

    generate
        for (genvar gi = 0; gi < DMEM_DEPTH; gi++) begin : g_dmem
            logic [3:0] nib_reg;
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    nib_reg <= 4'h0;
                end else if (ld_acc && (ptr_reg == PTR_W'(PROG_N + gi))) begin
                    nib_reg <= ld_data;
                end else if (!ld_en && wr && (daddr == 4'(gi))) begin
                    nib_reg <= wdata;
                end
            end
            assign dmem[gi] = nib_reg;
        end
    endgenerate

    // ------------------------------------------------------------ read path
    logic [PTR_W-1:0] fetch_slot;

    // Only meaningful on fetch cycles, where nib_sel is 0..2, so the slot
    // always lands inside the store.
    assign fetch_slot = PTR_W'(fetch_idx) * PTR_W'(NIB_PER_INSTR) + PTR_W'(nib_sel);

    always_comb begin
        bus_rdata = 4'h0;
        if (!ld_en) begin
            if (is_fetch) begin
                bus_rdata = prog_mem[fetch_slot];
            end else if (rd) begin
                bus_rdata = dmem[daddr];
            end
        end
    end

    // ------------------------------------------------------- protocol error
    logic proto_err_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            proto_err_reg <= 1'b0;
        end else if (!ld_en && err) begin
            proto_err_reg <= 1'b1;
        end
    end

    assign proto_err = proto_err_reg;

endmodule

// File: tb/tb_nibble_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_nibble_mem_responder
// Directed bench for nibble_mem_responder (PROG_AW = 4: 48 program slots
// followed by 16 data slots).
// -----------------------------------------------------------------------------
module tb_nibble_mem_responder;

    logic       clk;
    logic       rst_n;
    logic [7:0] bus_addr;
    logic [7:0] bus_ctl;
    logic [7:0] bus_oe;
    logic [3:0] bus_rdata;
    logic       ld_en;
    logic       ld_valid;
    logic [3:0] ld_data;
    logic       ld_ready;
    logic       ld_done;
    logic       proto_err;

    int checks   = 0;
    int failures = 0;

    nibble_mem_responder #(
        .PROG_AW (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus_addr  (bus_addr),
        .bus_ctl   (bus_ctl),
        .bus_oe    (bus_oe),
        .bus_rdata (bus_rdata),
        .ld_en     (ld_en),
        .ld_valid  (ld_valid),
        .ld_data   (ld_data),
        .ld_ready  (ld_ready),
        .ld_done   (ld_done),
        .proto_err (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs are then changed 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        ld_en    = 1'b0;
        ld_valid = 1'b0;
        ld_data  = 4'h0;
        bus_addr = 8'h00;
        bus_ctl  = 8'h00;
        bus_oe   = 8'h00;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        $display("[tb] reset: FETCH1 addr 0 -> rdata=%h ld_ready=%b proto_err=%b",
                 bus_rdata, ld_ready, proto_err);
        checks++;
        if (bus_rdata !== 4'h0) begin
            failures++;
            $display("FAIL reset_rdata got=%h exp=0", bus_rdata);
        end
        checks++;
        if (ld_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_ld_ready got=%b exp=0", ld_ready);
        end
        checks++;
        if (ld_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_ld_done got=%b exp=0", ld_done);
        end
        checks++;
        if (proto_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_proto_err got=%b exp=0", proto_err);
        end
        tick();
    endtask

    // Full load: slot s gets s mod 16.
    task automatic test_full_load();
        int ready_bad;
        ready_bad = 0;
        ld_en    = 1'b1;
        ld_valid = 1'b1;
        ld_data  = 4'hE;   // offered while still IDLE: must not be taken
        #1;
        checks++;
        if (ld_ready !== 1'b0) begin
            failures++;
            $display("FAIL load_first_cycle_ready got=%b exp=0", ld_ready);
        end
        tick();
        for (int i = 0; i < 64; i++) begin
            ld_data = 4'(i);
            #1;
            if (ld_ready !== 1'b1) ready_bad++;
            if (i < 63 && ld_done !== 1'b0) ready_bad++;
            tick();
        end
        ld_valid = 1'b0;
        $display("[tb] load: 64 nibbles streamed, ld_done=%b ld_ready=%b", ld_done, ld_ready);
        checks++;
        if (ready_bad != 0) begin
            failures++;
            $display("FAIL load_ready_during_stream bad_cycles=%0d exp=0", ready_bad);
        end
        checks++;
        if (ld_done !== 1'b1) begin
            failures++;
            $display("FAIL load_done got=%b exp=1", ld_done);
        end
        checks++;
        if (ld_ready !== 1'b0) begin
            failures++;
            $display("FAIL load_ready_after_done got=%b exp=0", ld_ready);
        end
        // Fetch while still in loader mode is masked.
        bus_addr = 8'h01;
        bus_ctl  = 8'h40;
        #1;
        checks++;
        if (bus_rdata !== 4'h0) begin
            failures++;
            $display("FAIL load_rdata_masked got=%h exp=0", bus_rdata);
        end
        ld_en = 1'b0;
        tick();
        checks++;
        if (ld_done !== 1'b0) begin
            failures++;
            $display("FAIL load_done_cleared got=%b exp=0", ld_done);
        end
    endtask

    task automatic test_fetch();
        // instr 5 nibble 0 = slot 15
        bus_addr = 8'h01; bus_ctl = 8'h40;
        #1;
        $display("[tb] fetch1 addr=%h ctl=%h -> rdata=%h", bus_addr, bus_ctl, bus_rdata);
        checks++;
        if (bus_rdata !== 4'hF) begin
            failures++;
            $display("FAIL fetch_i5_n0 got=%h exp=f", bus_rdata);
        end
        // instr 5 nibble 2 = slot 17 -> 1
        bus_ctl = 8'h60;
        #1;
        $display("[tb] fetch3 addr=%h ctl=%h -> rdata=%h", bus_addr, bus_ctl, bus_rdata);
        checks++;
        if (bus_rdata !== 4'h1) begin
            failures++;
            $display("FAIL fetch_i5_n2 got=%h exp=1", bus_rdata);
        end
        // slot 0 was offered 0xE while IDLE, but loaded with 0
        bus_addr = 8'h00; bus_ctl = 8'h00;
        #1;
        checks++;
        if (bus_rdata !== 4'h0) begin
            failures++;
            $display("FAIL fetch_slot0 got=%h exp=0", bus_rdata);
        end
        // instr 15 nibble 1 = slot 46 -> 0xE
        bus_addr = 8'h03; bus_ctl = 8'hD0;
        #1;
        checks++;
        if (bus_rdata !== 4'hE) begin
            failures++;
            $display("FAIL fetch_i15_n1 got=%h exp=e", bus_rdata);
        end
        tick();
    endtask

    task automatic test_alias();
        // PC = 20 -> instr 20 aliases to instr 4, nibble 0 = slot 12
        bus_addr = 8'h05; bus_ctl = 8'h00; bus_oe = 8'h00;
        #1;
        $display("[tb] alias fetch addr=%h ctl=%h -> rdata=%h", bus_addr, bus_ctl, bus_rdata);
        checks++;
        if (bus_rdata !== 4'hC) begin
            failures++;
            $display("FAIL alias_pc20 got=%h exp=c", bus_rdata);
        end
        tick();
    endtask

    task automatic test_write_read();
        // dmem[3] loaded from slot 51 -> 3
        bus_addr = 8'h03; bus_ctl = 8'h70; bus_oe = 8'h00;
        #1;
        checks++;
        if (bus_rdata !== 4'h3) begin
            failures++;
            $display("FAIL read_loaded_d3 got=%h exp=3", bus_rdata);
        end
        tick();
        bus_ctl = 8'h3A; bus_oe = 8'hFF;
        #1;
        $display("[tb] write addr=%h data=a -> rdata=%h", bus_addr, bus_rdata);
        checks++;
        if (bus_rdata !== 4'h0) begin
            failures++;
            $display("FAIL write_cycle_rdata got=%h exp=0", bus_rdata);
        end
        tick();
        bus_ctl = 8'h70; bus_oe = 8'h00;
        #1;
        $display("[tb] read addr=%h -> rdata=%h", bus_addr, bus_rdata);
        checks++;
        if (bus_rdata !== 4'hA) begin
            failures++;
            $display("FAIL read_after_write got=%h exp=a", bus_rdata);
        end
        checks++;
        if (proto_err !== 1'b0) begin
            failures++;
            $display("FAIL good_cycles_proto_err got=%b exp=0", proto_err);
        end
        tick();
    endtask

    task automatic test_bad_write();
        // dmem[5] loaded with 5; partial-enable write of 6 must be dropped
        bus_addr = 8'h05; bus_ctl = 8'h36; bus_oe = 8'hF0;
        #1;
        $display("[tb] bad write addr=%h oe=%h -> rdata=%h", bus_addr, bus_oe, bus_rdata);
        checks++;
        if (proto_err !== 1'b0) begin
            failures++;
            $display("FAIL bad_write_err_early got=%b exp=0", proto_err);
        end
        tick();
        bus_ctl = 8'h70; bus_oe = 8'h00;
        #1;
        checks++;
        if (proto_err !== 1'b1) begin
            failures++;
            $display("FAIL bad_write_err_set got=%b exp=1", proto_err);
        end
        checks++;
        if (bus_rdata !== 4'h5) begin
            failures++;
            $display("FAIL bad_write_dmem got=%h exp=5", bus_rdata);
        end
        bus_addr = 8'h00; bus_ctl = 8'h00;
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (proto_err !== 1'b1) begin
            failures++;
            $display("FAIL proto_err_sticky got=%b exp=1", proto_err);
        end
    endtask

    task automatic test_abort_reload();
        // First partial load: slots 0..9 <- (i+8)
        ld_en = 1'b1; ld_valid = 1'b0;
        tick();
        for (int i = 0; i < 10; i++) begin
            ld_valid = 1'b1; ld_data = 4'(i + 8);
            tick();
        end
        ld_valid = 1'b0; ld_en = 1'b0;
        tick();
        checks++;
        if (ld_ready !== 1'b0) begin
            failures++;
            $display("FAIL abort_ready got=%b exp=0", ld_ready);
        end
        bus_addr = 8'h00; bus_ctl = 8'h00;
        #1;
        checks++;
        if (bus_rdata !== 4'h8) begin
            failures++;
            $display("FAIL abort_slot0 got=%h exp=8", bus_rdata);
        end
        // Second load restarts at slot 0: slots 0..9 <- (15-i)
        ld_en = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) begin
            ld_valid = 1'b1; ld_data = 4'(15 - i);
            tick();
        end
        ld_valid = 1'b0; ld_en = 1'b0;
        tick();
        bus_addr = 8'h00; bus_ctl = 8'h00;   // slot 0
        #1;
        $display("[tb] reload fetch instr0 n0 -> rdata=%h", bus_rdata);
        checks++;
        if (bus_rdata !== 4'hF) begin
            failures++;
            $display("FAIL reload_slot0 got=%h exp=f", bus_rdata);
        end
        bus_addr = 8'h00; bus_ctl = 8'hC0;   // instr 3 nibble 0 = slot 9
        #1;
        checks++;
        if (bus_rdata !== 4'h6) begin
            failures++;
            $display("FAIL reload_slot9 got=%h exp=6", bus_rdata);
        end
        bus_ctl = 8'hD0;                     // instr 3 nibble 1 = slot 10
        #1;
        checks++;
        if (bus_rdata !== 4'hA) begin
            failures++;
            $display("FAIL reload_slot10_kept got=%h exp=a", bus_rdata);
        end
        tick();
    endtask

    task automatic test_reset_clear();
        // Reset while ld_en is high and a write is on the bus
        rst_n = 1'b0; ld_en = 1'b1;
        bus_addr = 8'h03; bus_ctl = 8'h35; bus_oe = 8'hFF;
        tick();
        rst_n = 1'b1; ld_en = 1'b0;
        bus_ctl = 8'h70; bus_oe = 8'h00;
        #1;
        $display("[tb] post-reset read addr=%h -> rdata=%h proto_err=%b",
                 bus_addr, bus_rdata, proto_err);
        checks++;
        if (proto_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_clears_err got=%b exp=0", proto_err);
        end
        checks++;
        if (ld_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_over_ld_en got=%b exp=0", ld_ready);
        end
        checks++;
        if (bus_rdata !== 4'h0) begin
            failures++;
            $display("FAIL reset_clears_dmem got=%h exp=0", bus_rdata);
        end
        bus_addr = 8'h01; bus_ctl = 8'h40;
        #1;
        checks++;
        if (bus_rdata !== 4'h0) begin
            failures++;
            $display("FAIL reset_clears_prog got=%h exp=0", bus_rdata);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_full_load();
        test_fetch();
        test_alias();
        test_write_read();
        test_bad_write();
        test_abort_reload();
        test_reset_clear();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
